mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single memory port (read/write address, write data, funct3, write enable, read data) between NUM_REQ requesters. Requester 0 is the risc_v core and requester 1 is a debug/loader master. Requests are accepted over a valid/ready handshake, issued to memory one at a time, and returned with a one-cycle response pulse. The block sits between the requesters and the memory instance in top and runs on the same 12 MHz clock.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  [NUM_REQ-1:0]  request pending, one bit per requester
req_ready  output  [NUM_REQ-1:0]  request accepted this cycle (one-hot or zero)
req_we  input  [NUM_REQ-1:0]  1 = store, 0 = load
req_addr  input  [NUM_REQ-1:0][ADDR_W-1:0]  byte address
req_wdata  input  [NUM_REQ-1:0][DATA_W-1:0]  store data
req_funct3  input  [NUM_REQ-1:0][2:0]  RISC-V load/store funct3
rsp_valid  output  [NUM_REQ-1:0]  one-cycle response pulse to the owning requester
rsp_rdata  output  DATA_W  load data, valid with rsp_valid; 0 for store acks
mem_wen  output  1  memory write enable
mem_ra  output  ADDR_W  memory read address
mem_wa  output  ADDR_W  memory write address
mem_wd  output  DATA_W  memory write data
mem_funct3  output  3  memory access size/sign
mem_rd  input  DATA_W  memory read data, one-cycle synchronous latency

Behaviour:
- Reset (async assert, sync release) forces:
  - state = IDLE
  - all outputs = 0
  - grant pointer = NUM_REQ-1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
- Acceptance (IDLE or RESP):
  - If any req_valid is set, req_ready goes high combinationally for exactly one winner.
  - Winner = first valid index after the pointer, round-robin with wrap from NUM_REQ-1 to 0.
  - On the handshake, the request fields and owner ID are registered, the pointer updates to the winner, and the next state is ISSUE.
  - With no valid request, the next state is IDLE.
- ISSUE (one cycle):
  - mem_ra, mem_wa, mem_wd and mem_funct3 are driven from the registers.
  - mem_wen = req_we of the registered request.
  - req_ready = 0.
  - Next state is RESP.
- RESP:
  - rsp_valid[owner] = 1 for exactly one cycle.
  - rsp_rdata = mem_rd for loads, 0 for stores.
  - A new acceptance may occur in the same cycle.
- Latency and throughput: accept at cycle T, memory access at T+1, response at T+2. Maximum throughput is one transaction per 2 cycles.
- Memory outputs outside ISSUE: mem_wen = 0; mem_ra, mem_wa, mem_wd and mem_funct3 hold their last values.
- Requester rules:
  - A requester must hold its fields stable while req_valid=1 && req_ready=0.
  - Deasserting req_valid before acceptance is legal; the request is simply dropped.
- Arbiter obligations:
  - rsp_valid is never asserted for a requester that has no transaction in flight.
  - At most one transaction is outstanding at any time.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ accept slots.
- Reset mid-operation: the in-flight transaction is discarded, mem_wen drops immediately, no rsp_valid is produced, and the pointer returns to its reset value.
- funct3 is passed through unmodified; byte-lane handling belongs to memory.

Optional Feature:
MEM_PORT_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins every tie (core always beats debug); the grant pointer is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package mem_port_arb_pkg contains:
  - state enum (IDLE, ISSUE, RESP)
  - funct3 constants: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010
  - request struct: we, addr, wdata, funct3
- Sub-module rr_grant contains the round-robin pointer and one-hot winner logic, and the MEM_PORT_ARB_FIXED_PRIO_EN switch.
- The FSM and registers stay in mem_port_arbiter.

Test Plan:
1. Hold rst_n low for 3 cycles, then release. Required: all outputs 0, req_ready=0 with no valid, mem_wen never asserted.
2. Memory word 0x100 = 0xDEADBEEF; requester 0 issues LW 0x100, accepted at T. Required: mem_ra=0x100 at T+1; rsp_valid=2'b01 and rsp_rdata=0xDEADBEEF at T+2 only.
3. Requester 1 issues SW 0x200 / 0x12345678, then requester 0 issues LW 0x200. Required: mem_wen high for exactly one cycle with mem_funct3=010; the load returns 0x12345678; the store ack has rsp_rdata=0.
4. Both requesters continuously valid for 6 transactions from reset. Required: grant order 0,1,0,1,0,1; accepts every 2 cycles; each rsp_valid goes to the matching owner.
5. Pull rst_n low during ISSUE of a SW. Required: mem_wen falls asynchronously, no rsp_valid afterwards; after release, the next tie goes to requester 0.
6. With MEM_PORT_ARB_FIXED_PRIO_EN defined, both requesters continuously valid for 4 transactions. Required: all 4 grants go to requester 0; requester 1 is accepted only once req_valid[0] drops.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared state encoding, RISC-V funct3 constants and the latched request record
// for mem_port_arbiter and its grant logic.
package mem_port_arb_pkg;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [2:0]            funct3;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Winner selection among valid requesters: round-robin after the last grant, or
// lowest-index-wins when MEM_PORT_ARB_FIXED_PRIO_EN is defined (no pointer then).
module rr_grant #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic w_found;

`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_update};

  always_comb begin
    w_found     = 1'b0;
    o_grant     = '0;
    o_grant_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_found && i_valid[j]) begin
        w_found     = 1'b1;
        o_grant[j]  = 1'b1;
        o_grant_idx = IDX_W'(j);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_ptr;

  // Two passes give "first valid after the pointer" with wrap to index 0.
  always_comb begin
    w_found     = 1'b0;
    o_grant     = '0;
    o_grant_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_found && i_valid[j] && (IDX_W'(j) > r_ptr)) begin
        w_found     = 1'b1;
        o_grant[j]  = 1'b1;
        o_grant_idx = IDX_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_found && i_valid[j] && (IDX_W'(j) <= r_ptr)) begin
        w_found     = 1'b1;
        o_grant[j]  = 1'b1;
        o_grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (i_update) begin
      r_ptr <= o_grant_idx;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between NUM_REQ requesters: accept, issue,
// respond. Build with MEM_PORT_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0][2:0]        req_funct3,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           mem_wen,
  output logic [ADDR_W-1:0]              mem_ra,
  output logic [ADDR_W-1:0]              mem_wa,
  output logic [DATA_W-1:0]              mem_wd,
  output logic [2:0]                     mem_funct3,
  input  logic [DATA_W-1:0]              mem_rd
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  mem_req_t           r_req;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_mem_wen;

  logic               w_accept_en;
  logic               w_handshake;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;

  rr_grant #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_grant (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (req_valid),
    .i_update   (w_handshake),
    .o_grant    (w_grant),
    .o_grant_idx(w_grant_idx)
  );

  assign w_accept_en = (r_state == IDLE) || (r_state == RESP);
  assign req_ready   = w_accept_en ? w_grant : '0;
  assign w_handshake = |req_ready;

  // The latched request doubles as the memory-side address/data registers, so
  // those outputs naturally hold their last values outside ISSUE.
  assign mem_ra     = r_req.addr[ADDR_W-1:0];
  assign mem_wa     = r_req.addr[ADDR_W-1:0];
  assign mem_wd     = r_req.wdata[DATA_W-1:0];
  assign mem_funct3 = r_req.funct3;
  assign mem_wen    = r_mem_wen;
  assign rsp_valid  = r_rsp_valid;

  // Memory read data only arrives in the RESP cycle, so it is steered, not registered.
  assign rsp_rdata = ((r_state == RESP) && !r_req.we) ? mem_rd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_owner     <= '0;
      r_rsp_valid <= '0;
      r_mem_wen   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, RESP: begin
          r_rsp_valid <= '0;
          if (w_handshake) begin
            r_req.we     <= req_we[w_grant_idx];
            r_req.addr   <= REQ_ADDR_W'(req_addr[w_grant_idx]);
            r_req.wdata  <= REQ_DATA_W'(req_wdata[w_grant_idx]);
            r_req.funct3 <= req_funct3[w_grant_idx];
            r_owner      <= w_grant_idx;
            r_mem_wen    <= req_we[w_grant_idx];
            r_state      <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_mem_wen   <= 1'b0;
          r_rsp_valid <= NUM_REQ'(1) << r_owner;
          r_state     <= RESP;
        end
        default: begin
          r_mem_wen   <= 1'b0;
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference: arbitration order, one-outstanding pipeline, word memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          req_we = '0;
  logic [N-1:0][AW-1:0]  req_addr = '0;
  logic [N-1:0][DW-1:0]  req_wdata = '0;
  logic [N-1:0][2:0]     req_funct3 = '0;
  logic [N-1:0]          rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  mem_wen;
  logic [AW-1:0]         mem_ra, mem_wa;
  logic [DW-1:0]         mem_wd;
  logic [2:0]            mem_funct3;
  logic [DW-1:0]         mem_rd = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_wen(mem_wen), .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  // Environment memory: word-wide, one-cycle synchronous read.
  logic [31:0] env_mem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_wen) env_mem[mem_wa] = mem_wd;
    mem_rd <= env_mem.exists(mem_ra) ? env_mem[mem_ra] : '0;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester-side pending requests.
  bit          pend [N];
  logic        p_we [N];
  logic [31:0] p_addr [N];
  logic [31:0] p_wd [N];
  logic [2:0]  p_f3 [N];

  typedef struct {
    int          owner;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
  } tr_t;

  tr_t         m_iss, m_rsp;
  bit          m_iss_v = 0, m_rsp_v = 0;
  int          m_last = N - 1;
  logic [31:0] ref_mem [logic [31:0]];
  int          grant_q [$];
  int          acc_cyc [$];
  int          cyc = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic int pick(input bit v [N]);
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (v[k]) return k;
`else
    for (int k = 1; k <= N; k++) begin
      int c = (m_last + k) % N;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic new_req(input int i, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3);
    pend[i] = 1; p_we[i] = we; p_addr[i] = a; p_wd[i] = d; p_f3[i] = f3;
  endtask

  task automatic rand_req(input int i);
    logic [2:0] ld [5];
    logic [2:0] st [3];
    bit we;
    ld = '{LB, LH, LW, LBU, LHU};
    st = '{SB, SH, SW};
    we = 1'($urandom_range(0, 1));
    new_req(i, we, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
            we ? st[$urandom_range(0, 2)] : ld[$urandom_range(0, 4)]);
  endtask

  // One clock: drive, check all outputs against the model, advance the model.
  task automatic step();
    logic [N-1:0] e_ready, e_rsp;
    int win;
    tr_t t;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i]; req_we[i] = p_we[i]; req_addr[i] = p_addr[i];
      req_wdata[i] = p_wd[i]; req_funct3[i] = p_f3[i];
    end
    #1;
    win = m_iss_v ? -1 : pick(pend);
    e_ready = '0;
    if (win >= 0) e_ready[win] = 1'b1;
    check("req_ready", req_ready, e_ready);
    e_rsp = '0;
    if (m_rsp_v) e_rsp[m_rsp.owner] = 1'b1;
    check("rsp_valid", rsp_valid, e_rsp);
    if (m_rsp_v) check("rsp_rdata", rsp_rdata, m_rsp.we ? 32'h0 : m_rsp.rdata);
    check("mem_wen", mem_wen, m_iss_v && m_iss.we);
    if (m_iss_v) begin
      check("mem_ra", mem_ra, m_iss.addr);
      check("mem_funct3", mem_funct3, m_iss.f3);
      if (m_iss.we) begin
        check("mem_wa", mem_wa, m_iss.addr);
        check("mem_wd", mem_wd, m_iss.wdata);
      end
    end
    m_rsp_v = m_iss_v;
    m_rsp   = m_iss;
    if (m_iss_v) begin
      if (m_iss.we) ref_mem[m_iss.addr] = m_iss.wdata;
      else m_rsp.rdata = ref_rd(m_iss.addr);
    end
    m_iss_v = (win >= 0);
    if (win >= 0) begin
      t.owner = win; t.we = p_we[win]; t.addr = p_addr[win];
      t.wdata = p_wd[win]; t.f3 = p_f3[win]; t.rdata = '0;
      m_iss = t;
      m_last = win;
      pend[win] = 0;
      grant_q.push_back(win);
      acc_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (3) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    req_valid = '0;
    rst_n = 1'b0;
    m_iss_v = 0; m_rsp_v = 0; m_last = N - 1;
    #1;
    check("rst_mem_wen_async", mem_wen, 0);
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_mem_wen", mem_wen, 0);
      check("rst_mem_ra", mem_ra, 0);
      check("rst_mem_wa", mem_wa, 0);
      check("rst_mem_wd", mem_wd, 0);
      check("rst_mem_funct3", mem_funct3, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_wd[i] = '0; p_f3[i] = '0;
    end
    do_reset();
    repeat (2) step();

    env_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    new_req(0, 0, 32'h100, 32'h0, LW);
    step();
    check("t2_grant0", grant_q[grant_q.size()-1], 0);
    drain();

    new_req(1, 1, 32'h200, 32'h12345678, SW);
    step();
    new_req(0, 0, 32'h200, 32'h0, LW);
    drain();
    check("t3_ref_store", ref_rd(32'h200), 32'h12345678);

    do_reset();
    grant_q.delete();
    acc_cyc.delete();
    for (int s = 0; s < 40 && grant_q.size() < 6; s++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) rand_req(i);
      step();
    end
    check("t4_grant_count", grant_q.size(), 6);
    for (int k = 0; k < grant_q.size(); k++) begin
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
      check("t4_grant_order", grant_q[k], 0);
`else
      check("t4_grant_order", grant_q[k], k % 2);
`endif
      if (k > 0) check("t4_accept_spacing", acc_cyc[k] - acc_cyc[k-1], 2);
    end
    pend[0] = 0;
    if (!pend[1]) rand_req(1);
    for (int s = 0; s < 6 && pend[1]; s++) step();
    check("t6_rq1_after_drop", pend[1], 0);
    drain();

    new_req(0, 1, 32'h200, 32'hBAD0BAD0, SW);
    step();
    @(negedge clk); #1;
    check("t5_wen_in_issue", mem_wen, 1);
    do_reset();
    new_req(0, 0, 32'h200, 32'h0, LW);
    new_req(1, 0, 32'h100, 32'h0, LW);
    grant_q.delete();
    step();
    check("t5_tie_after_reset", grant_q[0], 0);
    for (int s = 0; s < 8 && pend[1]; s++) step();
    drain();
    check("t5_store_discarded", ref_rd(32'h200), 32'h12345678);

    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) rand_req(i);
        else if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 0;
      end
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
